mult_seq_32bit: RTL and testbench

Sequential shift-add 32x32 multiplier for the ALU datapath. It consumes operands prepared by the bitwise stage, where the 32-bit inverter supplies ones'-complement operands for negation. It produces a 64-bit product over a fixed number of cycles using a start/done handshake. Result and status are registered, so the ALU output mux can sample them directly.

---
 rtl/mult_pkg.sv | 17 +
 rtl/mult_seq_ctrl.sv | 67 ++++++
 rtl/mult_seq_32bit.sv | 112 +++++++++++
 tb/tb_mult_seq_32bit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// mult_pkg
// Shared constants and types for the sequential shift-add multiplier.
//   WIDTH : default operand width (product is 2*WIDTH bits)
//   CNT_W : iteration counter width for the default WIDTH
//   state_t : controller states {IDLE, CALC}
// Optional feature macro used by the multiplier: SIGNED_MULT_EN.
package mult_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

endpackage

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl
// FSM and iteration counter for the shift-add multiplier.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-high reset
//   start  in   operation request, honoured only in IDLE
//   load   out  datapath strobe: latch operands this edge
//   step   out  datapath strobe: perform one iteration this edge
//   finish out  datapath strobe: this edge is the final iteration
//   busy   out  registered, high while an operation is in progress
module mult_seq_ctrl
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = mult_pkg::WIDTH
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic load,
    output logic step,
    output logic finish,
    output logic busy
);

    localparam int unsigned CW = $clog2(WIDTH);

    state_t        state;
    logic [CW-1:0] cnt;

    // Strobes are decodes of registered state so the datapath acts on
    // the same edge the FSM transitions.
    always_comb begin
        load   = (state == IDLE) && start;
        step   = (state == CALC);
        finish = (state == CALC) && (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= CALC;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CALC: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mult_seq_32bit.sv
// mult_seq_32bit
// Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, one
// iteration per cycle, start-to-done latency of exactly WIDTH cycles.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-high reset, clears all state
//   start  in   request, sampled only when idle
//   input1 in   multiplicand [WIDTH-1:0]
//   input2 in   multiplier   [WIDTH-1:0]
//   busy   out  high while an operation is in progress
//   done   out  one-cycle pulse when result is updated
//   result out  last completed product [2*WIDTH-1:0], held until next
// Configuration macro: SIGNED_MULT_EN (two's-complement operands when
// defined; pure unsigned multiply otherwise).
module mult_seq_32bit
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = mult_pkg::WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     input1,
    input  logic [WIDTH-1:0]     input2,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

    localparam int unsigned PW = 2 * WIDTH;

    logic             load;
    logic             step;
    logic             finish;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH:0]   sum;
    logic [PW-1:0]    prod;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;

    mult_seq_ctrl #(
        .WIDTH (WIDTH)
    ) u_ctrl (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .load   (load),
        .step   (step),
        .finish (finish),
        .busy   (busy)
    );

`ifdef SIGNED_MULT_EN
    logic sign_q;

    // Operands are reduced to magnitudes at load; 0x80..0 maps to itself,
    // which read unsigned is the correct magnitude.
    always_comb begin
        op1 = input1[WIDTH-1] ? (~input1 + WIDTH'(1)) : input1;
        op2 = input2[WIDTH-1] ? (~input2 + WIDTH'(1)) : input2;
    end
`else
    always_comb begin
        op1 = input1;
        op2 = input2;
    end
`endif

    // One iteration: conditional add at WIDTH+1 bits, then the
    // {carry, acc_hi, mplier} shift. prod is the post-shift value.
    always_comb begin
        sum  = mplier[0] ? ({1'b0, acc_hi} + {1'b0, mcand}) : {1'b0, acc_hi};
        prod = {sum, mplier[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand  <= '0;
            acc_hi <= '0;
            mplier <= '0;
            result <= '0;
            done   <= 1'b0;
`ifdef SIGNED_MULT_EN
            sign_q <= 1'b0;
`endif
        end else begin
            done <= finish;
            if (load) begin
                mcand  <= op1;
                mplier <= op2;
                acc_hi <= '0;
`ifdef SIGNED_MULT_EN
                sign_q <= input1[WIDTH-1] ^ input2[WIDTH-1];
`endif
            end else if (step) begin
                acc_hi <= prod[PW-1:WIDTH];
                mplier <= prod[WIDTH-1:0];
            end
            if (finish) begin
`ifdef SIGNED_MULT_EN
                result <= sign_q ? (~prod + PW'(1)) : prod;
`else
                result <= prod;
`endif
            end
        end
    end

endmodule

// File: tb/tb_mult_seq_32bit.sv
// tb_mult_seq_32bit
// Directed self-checking bench for mult_seq_32bit. Expected products are
// queued when an operation is started and popped when done pulses.
// Honours SIGNED_MULT_EN for expected values.
module tb_mult_seq_32bit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] input1;
    logic [31:0] input2;
    logic        busy;
    logic        done;
    logic [63:0] result;

    int          tests;
    int          fails;
    logic [63:0] sb[$];

    mult_seq_32bit #(
        .WIDTH (32)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .input1 (input1),
        .input2 (input2),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
`ifdef SIGNED_MULT_EN
        ea = {{32{a[31]}}, a};
        eb = {{32{b[31]}}, b};
        return 64'($signed(ea) * $signed(eb));
`else
        ea = {32'b0, a};
        eb = {32'b0, b};
        return ea * eb;
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for done, counting edges; 0 means the bound expired.
    task automatic wait_done(output int cycles);
        cycles = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (done === 1'b1) begin
                cycles = k;
                return;
            end
        end
    endtask

    task automatic check_result(input string tag);
        logic [63:0] exp;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
        end else begin
            exp = sb.pop_front();
            check(tag, result, exp);
        end
    endtask

    // Start one op, check its latency, result, busy and done pulse width.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp);
        int cyc;
        start  = 1'b1;
        input1 = a;
        input2 = b;
        sb.push_back(exp);
        tick();
        start  = 1'b0;
        input1 = $urandom;
        input2 = $urandom;
        check({tag, "_busy_hi"}, 64'(busy), 64'd1);
        wait_done(cyc);
        check({tag, "_latency"}, 64'(cyc), 64'd32);
        check({tag, "_busy_lo"}, 64'(busy), 64'd0);
        check_result(tag);
        tick();
        check({tag, "_done_fall"}, 64'(done), 64'd0);
    endtask

    initial begin
        int          cyc;
        logic [31:0] ra;
        logic [31:0] rb;
        tests  = 0;
        fails  = 0;
        reset  = 1'b1;
        start  = 1'b0;
        input1 = '0;
        input2 = '0;

        tick();
        tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", result, 64'h0);
        reset = 1'b0;
        tick();

        run_op("3x5", 32'd3, 32'd5, 64'h000000000000000F);
`ifdef SIGNED_MULT_EN
        run_op("ffxff", 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001);
        run_op("fdx7", 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFFFFFFFFEB);
`else
        run_op("ffxff", 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001);
        run_op("fdx7", 32'hFFFFFFFD, 32'd7, 64'h00000006FFFFFFEB);
`endif
        run_op("80x80", 32'h80000000, 32'h80000000, 64'h4000000000000000);
        run_op("zero", 32'd0, 32'hDEADBEEF, 64'h0);

        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            run_op($sformatf("rand%0d", i), ra, rb, model(ra, rb));
        end

        // start during CALC must be ignored and not remembered.
        start  = 1'b1;
        input1 = 32'd4;
        input2 = 32'd4;
        sb.push_back(64'h10);
        tick();
        start = 1'b0;
        cyc   = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 9) begin
                start  = 1'b1;
                input1 = 32'd9;
                input2 = 32'd9;
            end
            if (k == 10) start = 1'b0;
            tick();
            if (done === 1'b1) begin
                cyc = k;
                break;
            end
        end
        start = 1'b0;
        check("ign_latency", 64'(cyc), 64'd32);
        check_result("ign_result");
        cyc = 0;
        for (int k = 1; k <= 36; k++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) cyc = k;
        end
        check("ign_no_second_op", 64'(cyc), 64'd0);

        // Held start: back-to-back ops, second sampled one cycle after done.
        ra = 32'h12345678;
        rb = 32'h9ABCDEF0;
        start  = 1'b1;
        input1 = 32'd11;
        input2 = 32'd13;
        sb.push_back(model(32'd11, 32'd13));
        sb.push_back(model(ra, rb));
        tick();
        input1 = ra;
        input2 = rb;
        wait_done(cyc);
        check("b2b_first_latency", 64'(cyc), 64'd32);
        check_result("b2b_first");
        tick();
        start = 1'b0;
        check("b2b_second_busy", 64'(busy), 64'd1);
        wait_done(cyc);
        check("b2b_second_latency", 64'(cyc), 64'd32);
        check_result("b2b_second");
        tick();

        // Reset mid-operation clears outputs at once; no partial result.
        start  = 1'b1;
        input1 = 32'd5;
        input2 = 32'd7;
        tick();
        start = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        #2 reset = 1'b1;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_result", result, 64'h0);
        tick();
        reset = 1'b0;
        cyc = 0;
        for (int k = 1; k <= 36; k++) begin
            tick();
            if (done === 1'b1) cyc = k;
        end
        check("midrst_no_publish", 64'(cyc), 64'd0);
        run_op("post_rst_2x3", 32'd2, 32'd3, 64'd6);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
